truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Self-contained exhaustive stimulus/checker for small combinational DUTs (lab logic functions).
//  Walks all 2^N_IN input vectors in binary or Gray order, holding each for HOLD cycles.
//  Samples DUT response on the last hold cycle and compares it against a parametrised expected truth table.
//  Reports pass/fail, mismatch count and first failing vector.
//  Sits beside the DUT in a bench or on-board self-test wrapper; replaces hand-written vector lists.
// PARAMETERS
//  N_IN       4                      DUT input width; vectors 0 .. 2^N_IN-1
//  N_OUT      1                      DUT output width
//  HOLD       2                      cycles each vector is held; legal range >=2
//  EXP_TABLE  {(N_OUT*2^N_IN){1'b0}} expected outputs; entry for vector v = EXP_TABLE[v*N_OUT +: N_OUT]
// PORTS
//  clk             in   1          single clock, rising edge
//  rst             in   1          synchronous, active-high reset
//  start           in   1          pulse; accepted only in IDLE or DONE
//  gray_mode       in   1          sampled with accepted start: 0 = binary order, 1 = Gray order
//  vec_out         out  N_IN       stimulus vector to DUT
//  dut_resp        in   N_OUT      DUT output
//  busy            out  1          sweep in progress
//  done            out  1          sweep complete; held until next accepted start or rst
//  pass            out  1          valid when done: 1 iff err_count==0
//  err_count       out  N_IN+1     number of mismatching vectors (saturation impossible: max 2^N_IN)
//  fail_valid      out  1          at least one mismatch recorded this sweep
//  first_fail_vec  out  N_IN       applied vector value of first mismatch
// BEHAVIOUR
//  - Reset: state=IDLE.
//    All outputs are 0: vec_out, busy, done, pass, err_count, fail_valid, first_fail_vec.
//    rst wins over start in the same cycle.
//  - FSM: IDLE -> (start) -> APPLY -> ... -> DONE -> (start) -> APPLY. No other transitions.
//  - Accepted start: idx<=0, hold_cnt<=0, err_count<=0, fail_valid<=0, first_fail_vec<=0, done<=0, pass<=0.
//    mode latched from gray_mode; busy<=1.
//    start while busy is ignored.
//  - APPLY:
//    - vec_out = mode ? idx ^ (idx>>1) : idx, registered.
//    - vec_out changes only on the cycle hold_cnt returns to 0.
//    - hold_cnt counts 0..HOLD-1.
//  - Compare:
//    - At hold_cnt==HOLD-1, dut_resp is compared with the EXP_TABLE entry indexed by vec_out (the applied value, not idx).
//    - On mismatch: err_count++. If fail_valid==0: first_fail_vec<=vec_out and fail_valid<=1.
//  - Advance: same cycle as compare. If idx==2^N_IN-1 -> DONE (busy<=0, done<=1, pass<=(final err_count==0)); else idx++ and hold_cnt<=0.
//  - Latency: start accepted at edge k -> done high after edge k + 2^N_IN*HOLD. First vector (0) is visible the cycle after the accept edge.
//  - DONE: vec_out holds the last vector. Counters and flags are frozen until start or rst.
//  - rst mid-sweep aborts immediately to IDLE; no partial results are retained.
//  - idx is N_IN+0 bits; the terminal test is on idx, so there is no wrap-around beyond 2^N_IN-1.
// STRUCTURE
//  - sweeper_pkg:
//    - state enum {IDLE, APPLY, DONE}.
//    - function bin2gray(N_IN).
//    - localparam NVEC = 1<<N_IN.
//  - One sub-module: sweep_vec_encoder. Combinational idx + mode -> next vector, using bin2gray.
//  - Top holds the FSM, hold counter, compare and result registers. EXP_TABLE lookup is an indexed part-select.
// TESTING (N_IN=4, N_OUT=1, HOLD=2, behavioural DUT model)
//  1. Binary mode, DUT correct, EXP_TABLE=16'hA5A5.
//     -> vec_out steps 0,1,..,15, each held 2 cycles; done 32 cycles after start; pass=1, err_count=0, fail_valid=0.
//  2. gray_mode=1, DUT correct.
//     -> vec_out sequence 0,1,3,2,6,7,5,4,12,..,8; pass=1, err_count=0.
//  3. DUT stuck-at-0, EXP_TABLE=16'hA5A5.
//     -> err_count=8, fail_valid=1, first_fail_vec=0, pass=0.
//  4. DUT inverts output only at vector 4'hB, binary mode.
//     -> err_count=1, first_fail_vec=4'hB.
//     Repeat in gray mode -> same result.
//  5. rst pulsed while vec_out==7.
//     -> next cycle busy=0, vec_out=0, err_count=0, done=0.
//     A following start restarts from vector 0.
//  6. start pulsed while busy -> ignored, sweep completes unchanged.
//     start in DONE -> counters and flags cleared and a new sweep begins.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared types and helpers for the truth-table sweeper
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The package cannot see the top's N_IN, so the vector count is derived through a function.
    function automatic int unsigned nvec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // Width-generic Gray encoding; callers truncate the result to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_vec_encoder.sv
// rtl/truth_table_sweeper_vec_encoder.sv - maps sweep index to applied vector (binary or Gray)
module sweep_vec_encoder
    import sweeper_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [N_IN-1:0] idx,
    input  logic            mode,
    output logic [N_IN-1:0] vec
);

    assign vec = mode ? N_IN'(bin2gray(32'(idx))) : idx;

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive stimulus generator and truth-table checker
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int                              N_IN      = 4,
    parameter int                              N_OUT     = 1,
    parameter int                              HOLD      = 2,
    parameter logic [N_OUT*(1<<N_IN)-1:0]      EXP_TABLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              gray_mode,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  dut_resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   first_fail_vec
);

    localparam int unsigned NVEC   = nvec(N_IN);
    localparam int          HOLD_W = $clog2(HOLD);

    state_t              state, state_nxt;
    logic [N_IN-1:0]     idx;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                mode;
    logic [N_IN-1:0]     vec_nxt;
    logic [N_OUT-1:0]    exp_entry;
    logic                accept;
    logic                last_hold;
    logic                last_vec;
    logic                mismatch;

    // Encoder looks one index ahead so vec_out can be registered on the advance edge.
    sweep_vec_encoder #(.N_IN(N_IN)) u_enc (
        .idx  (idx + 1'b1),
        .mode (mode),
        .vec  (vec_nxt)
    );

    // Look up by the applied vector, which differs from idx in Gray mode.
    assign exp_entry = EXP_TABLE[int'(vec_out)*N_OUT +: N_OUT];

    assign busy = (state == APPLY);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        accept    = start && (state != APPLY);
        last_hold = (hold_cnt == HOLD_W'(HOLD-1));
        last_vec  = (idx == N_IN'(NVEC-1));
        mismatch  = (dut_resp != exp_entry);
        case (state)
            IDLE, DONE: if (accept) state_nxt = APPLY;
            APPLY:      if (last_hold && last_vec) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            hold_cnt       <= '0;
            mode           <= 1'b0;
            vec_out        <= '0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else if (accept) begin
            idx            <= '0;
            hold_cnt       <= '0;
            mode           <= gray_mode;
            vec_out        <= '0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else if (state == APPLY) begin
            if (last_hold) begin
                if (mismatch) begin
                    err_count <= err_count + 1'b1;
                    if (!fail_valid) begin
                        first_fail_vec <= vec_out;
                        fail_valid     <= 1'b1;
                    end
                end
                // Final vector: fold this compare into pass and leave vec_out on the last vector.
                if (last_vec) begin
                    pass <= (err_count == '0) && !mismatch;
                end else begin
                    idx      <= idx + 1'b1;
                    hold_cnt <= '0;
                    vec_out  <= vec_nxt;
                end
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    localparam int          N_IN  = 4;
    localparam int          N_OUT = 1;
    localparam int          HOLD  = 2;
    localparam logic [15:0] EXP   = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        gray_mode = 1'b0;
    logic [3:0]  vec_out;
    logic [0:0]  dut_resp;
    logic        busy, done, pass, fail_valid;
    logic [4:0]  err_count;
    logic [3:0]  first_fail_vec;

    logic [15:0] exp_tab = EXP;
    logic [15:0] fault_mask = 16'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural DUT: correct function with selected vectors inverted.
    always_comb dut_resp = exp_tab[vec_out] ^ fault_mask[vec_out];

    truth_table_sweeper #(
        .N_IN(N_IN), .N_OUT(N_OUT), .HOLD(HOLD), .EXP_TABLE(EXP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .gray_mode(gray_mode),
        .vec_out(vec_out), .dut_resp(dut_resp), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_valid(fail_valid),
        .first_fail_vec(first_fail_vec)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: the n-th vector in sweep order.
    function automatic int ref_vec(input int n, input logic gm);
        return gm ? (n ^ (n / 2)) : n;
    endfunction

    task automatic run_sweep(input string tag, input logic gm, input logic [15:0] mask,
                             input logic poke_busy);
        int exp_err;
        int exp_first;
        int v;
        exp_err   = 0;
        exp_first = -1;
        for (int n = 0; n < 16; n++) begin
            v = ref_vec(n, gm);
            if (mask[v]) begin
                exp_err++;
                if (exp_first < 0) exp_first = v;
            end
        end
        fault_mask = mask;
        @(negedge clk);
        start = 1'b1;
        gray_mode = gm;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 2 * 16; c++) begin
            @(negedge clk);
            check({tag, " vec"}, 32'(vec_out), 32'(ref_vec(c / HOLD, gm)));
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done_low"}, 32'(done), 32'd0);
            if (c == 0) begin
                check({tag, " err_cleared"}, 32'(err_count), 32'd0);
                check({tag, " fv_cleared"}, 32'(fail_valid), 32'd0);
            end
            if (poke_busy && c == 9) begin
                start = 1'b1;
                gray_mode = ~gm;
                @(posedge clk);
                #1 start = 1'b0;
                gray_mode = gm;
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check({tag, " done"}, 32'(done), 32'd1);
            check({tag, " busy_end"}, 32'(busy), 32'd0);
            check({tag, " vec_hold"}, 32'(vec_out), 32'(ref_vec(15, gm)));
            check({tag, " pass"}, 32'(pass), 32'(exp_err == 0));
            check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
            check({tag, " fail_valid"}, 32'(fail_valid), 32'(exp_err != 0));
            check({tag, " first_fail"}, 32'(first_fail_vec), 32'(exp_err != 0 ? exp_first : 0));
        end
    endtask

    initial begin
        logic found;
        logic [15:0] rmask;
        logic        rgm;

        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst vec", 32'(vec_out), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst pass", 32'(pass), 32'd0);
        check("rst err", 32'(err_count), 32'd0);
        check("rst fv", 32'(fail_valid), 32'd0);
        check("rst ffv", 32'(first_fail_vec), 32'd0);

        run_sweep("bin_ok", 1'b0, 16'h0000, 1'b0);
        run_sweep("gray_ok", 1'b1, 16'h0000, 1'b0);
        run_sweep("stuck0", 1'b0, EXP, 1'b0);
        run_sweep("invB_bin", 1'b0, 16'h0800, 1'b0);
        run_sweep("invB_gray", 1'b1, 16'h0800, 1'b0);
        run_sweep("busy_start", 1'b0, 16'h0120, 1'b1);

        for (int r = 0; r < 4; r++) begin
            rmask = 16'($urandom);
            rgm   = 1'($urandom_range(0, 1));
            run_sweep("random", rgm, rmask, 1'b0);
        end

        // Abort mid-sweep once vector 7 is on the bus.
        fault_mask = EXP;
        @(negedge clk);
        start = 1'b1;
        gray_mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (vec_out == 4'd7) found = 1'b1;
        end
        check("abort reached7", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort vec", 32'(vec_out), 32'd0);
        check("abort err", 32'(err_count), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort fv", 32'(fail_valid), 32'd0);
        run_sweep("after_abort", 1'b0, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
